// File: rtl/nibble_collector.sv
// Serial-to-parallel collector: packs accepted bits (LSB first) into 4-bit words
// held in a one-entry ready/valid output stage, with flush of partial words.
module nibble_collector (
    input  logic [1:0] clock_reset,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_word,
    output logic       out_any,
    output logic [2:0] fill
);

    // Handshake semantics: a bit transfers on a rising edge where in_valid & in_ready;
    // a word transfers where out_valid & out_ready. Neither valid may depend on ready.
    logic       clk;
    logic       rst_n;
    logic [3:0] sr;
    logic [1:0] cnt;
    logic       slot_free;
    logic       accept;
    logic       complete;
    logic       do_flush;
    logic       drain;
    logic [3:0] merged;

    assign clk   = clock_reset[0];
    assign rst_n = clock_reset[1];

    assign slot_free = !out_valid | out_ready;
    assign in_ready  = rst_n & ((cnt != 2'd3) | slot_free);
    assign accept    = in_valid & in_ready;
    assign complete  = accept & (cnt == 2'd3);
    assign drain     = out_valid & out_ready;
    // Flush only fires when something is held or arriving; completion wins.
    assign do_flush  = flush & !complete & slot_free & (accept | (cnt != 2'd0));
    assign fill      = {1'b0, cnt};

    // Shift register contents including this cycle's accepted bit.
    always_comb begin
        merged = sr;
        if (accept) begin
            merged[cnt] = in_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr        <= 4'd0;
            cnt       <= 2'd0;
            out_valid <= 1'b0;
            out_word  <= 4'd0;
            out_any   <= 1'b0;
        end else if (complete || do_flush) begin
            out_word  <= merged;
            out_any   <= |merged;
            out_valid <= 1'b1;
            sr        <= 4'd0;
            cnt       <= 2'd0;
        end else begin
            if (accept) begin
                sr  <= merged;
                cnt <= cnt + 2'd1;
            end
            if (drain) begin
                out_valid <= 1'b0;
                out_word  <= 4'd0;
                out_any   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nibble_collector.sv
// Directed table-driven bench for nibble_collector plus hand sequences for
// flush/completion overlap.
module tb_nibble_collector;

    typedef struct {
        logic       rst_n;
        logic       iv;
        logic       b;
        logic       fl;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [3:0] e_w;
        logic       e_any;
        logic [2:0] e_fill;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_word;
    logic       out_any;
    logic [2:0] fill;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[64];
    int   nvec = 0;

    always #5 clk = ~clk;

    nibble_collector dut (
        .clock_reset ({rst_n, clk}),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_any     (out_any),
        .fill        (fill)
    );

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic iv, input logic b, input logic fl, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [3:0] e_w, input logic e_any,
                       input logic [2:0] e_fill);
        vecs[nvec] = '{r, iv, b, fl, ordy, e_ir, e_ov, e_w, e_any, e_fill};
        nvec++;
    endtask

    task automatic drive(input logic r, input logic iv, input logic b, input logic fl, input logic ordy);
        rst_n     = r;
        in_valid  = iv;
        in_bit    = b;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic check_out(input int idx, input logic ov, input logic [3:0] w, input logic any,
                             input logic [2:0] f);
        chk("out_valid", idx, {3'b0, out_valid}, {3'b0, ov});
        chk("out_word", idx, out_word, w);
        chk("out_any", idx, {3'b0, out_any}, {3'b0, any});
        chk("fill", idx, {1'b0, fill}, {1'b0, f});
    endtask

    initial begin
        // reset held two edges with in_valid high
        add(0,1,1,0,1, 0, 0,4'b0000,0,0);
        add(0,1,1,0,1, 0, 0,4'b0000,0,0);
        // basic word: bits 1,1,0,0 -> 0011
        add(1,1,1,0,1, 1, 0,4'b0000,0,1);
        add(1,1,1,0,1, 1, 0,4'b0000,0,2);
        add(1,1,0,0,1, 1, 0,4'b0000,0,3);
        add(1,1,0,0,1, 1, 1,4'b0011,1,0);
        add(1,0,0,0,1, 1, 0,4'b0000,0,0);
        // eight zero bits back to back
        add(1,1,0,0,1, 1, 0,4'b0000,0,1);
        add(1,1,0,0,1, 1, 0,4'b0000,0,2);
        add(1,1,0,0,1, 1, 0,4'b0000,0,3);
        add(1,1,0,0,1, 1, 1,4'b0000,0,0);
        add(1,1,0,0,1, 1, 0,4'b0000,0,1);
        add(1,1,0,0,1, 1, 0,4'b0000,0,2);
        add(1,1,0,0,1, 1, 0,4'b0000,0,3);
        add(1,1,0,0,1, 1, 1,4'b0000,0,0);
        add(1,0,0,0,1, 1, 0,4'b0000,0,0);
        // backpressure: word 1010 (bits 0,1,0,1), then 1,1,0 and a stalled 4th bit
        add(1,1,0,0,0, 1, 0,4'b0000,0,1);
        add(1,1,1,0,0, 1, 0,4'b0000,0,2);
        add(1,1,0,0,0, 1, 0,4'b0000,0,3);
        add(1,1,1,0,0, 1, 1,4'b1010,1,0);
        add(1,1,1,0,0, 1, 1,4'b1010,1,1);
        add(1,1,1,0,0, 1, 1,4'b1010,1,2);
        add(1,1,0,0,0, 1, 1,4'b1010,1,3);
        add(1,1,1,0,0, 0, 1,4'b1010,1,3);
        add(1,1,1,0,1, 1, 1,4'b1011,1,0);
        add(1,0,0,0,1, 1, 0,4'b0000,0,0);
        // flush after bits 1,0 -> 0001
        add(1,1,1,0,1, 1, 0,4'b0000,0,1);
        add(1,1,0,0,1, 1, 0,4'b0000,0,2);
        add(1,0,0,1,1, 1, 1,4'b0001,1,0);
        add(1,0,0,0,1, 1, 0,4'b0000,0,0);
        // flush with nothing held is a no-op
        add(1,0,0,1,1, 1, 0,4'b0000,0,0);
        // flush together with a 3rd accepted bit 1 -> 0101
        add(1,1,1,0,1, 1, 0,4'b0000,0,1);
        add(1,1,0,0,1, 1, 0,4'b0000,0,2);
        add(1,1,1,1,1, 1, 1,4'b0101,1,0);
        add(1,0,0,0,1, 1, 0,4'b0000,0,0);
        // fill=2 with a held word; flush ignored while the slot is occupied
        add(1,1,1,0,0, 1, 0,4'b0000,0,1);
        add(1,1,0,0,0, 1, 0,4'b0000,0,2);
        add(1,0,0,1,0, 1, 1,4'b0001,1,0);
        add(1,1,1,0,0, 1, 1,4'b0001,1,1);
        add(1,1,0,0,0, 1, 1,4'b0001,1,2);
        add(1,0,0,1,0, 1, 1,4'b0001,1,2);
        // mid-operation reset, then bits 1,0,0,0 -> 0001
        add(0,1,1,0,0, 0, 0,4'b0000,0,0);
        add(1,1,1,0,1, 1, 0,4'b0000,0,1);
        add(1,1,0,0,1, 1, 0,4'b0000,0,2);
        add(1,1,0,0,1, 1, 0,4'b0000,0,3);
        add(1,1,0,0,1, 1, 1,4'b0001,1,0);
        add(1,0,0,0,1, 1, 0,4'b0000,0,0);

        @(posedge clk);
        #1;
        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].rst_n, vecs[i].iv, vecs[i].b, vecs[i].fl, vecs[i].ordy);
            #1;
            chk("in_ready", i, {3'b0, in_ready}, {3'b0, vecs[i].e_ir});
            @(posedge clk);
            #1;
            check_out(i, vecs[i].e_ov, vecs[i].e_w, vecs[i].e_any, vecs[i].e_fill);
        end

        // completion coinciding with flush: bits 1,1,1 then 0 with flush -> 0111
        drive(1,1,1,0,1); @(posedge clk); #1;
        drive(1,1,1,0,1); @(posedge clk); #1;
        drive(1,1,1,0,1); @(posedge clk); #1;
        check_out(100, 0, 4'b0000, 0, 3);
        drive(1,1,0,1,1); @(posedge clk); #1;
        check_out(101, 1, 4'b0111, 1, 0);
        // flush still held but register empty: word drains, nothing new
        drive(1,0,0,1,1); @(posedge clk); #1;
        check_out(102, 0, 4'b0000, 0, 0);

        // stall released by a drain with no new bit: stays at fill 3
        drive(1,1,1,0,0); @(posedge clk); #1;
        drive(1,1,0,0,0); @(posedge clk); #1;
        drive(1,1,1,0,0); @(posedge clk); #1;
        drive(1,1,1,0,0); @(posedge clk); #1;
        check_out(103, 1, 4'b1101, 1, 0);
        drive(1,1,0,0,0); @(posedge clk); #1;
        drive(1,1,1,0,0); @(posedge clk); #1;
        drive(1,1,1,0,0); @(posedge clk); #1;
        #1;
        chk("in_ready", 104, {3'b0, in_ready}, 4'd0);
        drive(1,0,0,0,1);
        #1;
        chk("in_ready", 105, {3'b0, in_ready}, 4'd1);
        @(posedge clk); #1;
        check_out(106, 0, 4'b0000, 0, 3);
        drive(1,1,0,0,1); @(posedge clk); #1;
        check_out(107, 1, 4'b0110, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_collector.md
# nibble_collector

Serial-to-parallel collector that assembles single accepted bits into 4-bit words and presents them on a one-entry ready/valid output stage with an OR-reduction flag. It is the writer side for any-reduction consumers in the flow-graph test circuits: it produces the 4-bit vectors that those blocks read. It also supports a flush that emits a partially filled word. It sits between a 1-bit producer and a 4-bit consumer inside a synchronous circuit.

## Interface
Parameters: none (word width fixed at 4).
- clock_reset  in  2  bit 0 = clock (rising edge active), bit 1 = reset_n; one clock; reset is synchronous and active-low
- in_valid  in  1  producer offers in_bit this cycle
- in_bit  in  1  serial data bit, LSB first
- in_ready  out  1  block can accept a bit this cycle
- flush  in  1  emit the partial word (sampled every cycle)
- out_valid  out  1  out_word holds a complete or flushed word
- out_ready  in  1  consumer takes out_word this cycle
- out_word  out  4  assembled word; first accepted bit in bit 0
- out_any  out  1  OR of out_word bits; 0 whenever out_valid = 0
- fill  out  3  bits held in the shift register (0..3)

## Operation
- Internal state:
  - sr[3:0] shift register
  - cnt 0..3 (drives fill)
  - output register {out_valid, out_word}
- Accept = in_valid & in_ready. An accepted bit is written to sr[cnt], then cnt increments.
- Drain = out_valid & out_ready. On drain, out_valid and out_word both clear to 0, unless a new word loads in the same edge.
- slot_free = !out_valid | out_ready. This is combinational through out_ready.
- in_ready = reset_n & (cnt != 3 | slot_free).
- Word completion: when a bit is accepted with cnt = 3 (and slot_free):
  - out_word loads {in_bit, sr[2:0]}; out_valid = 1
  - sr clears to 0; cnt clears to 0
- Flush, when flush = 1, no completion this cycle, and slot_free:
  - Effective count is cnt plus 1 if a bit is accepted this cycle.
  - If the effective count is > 0: out_word loads sr including the accepted bit, with unfilled high bits = 0. out_valid = 1; sr and cnt clear.
  - If the effective count is 0: no-op.
  - If slot_free is 0: flush is ignored. The producer must hold flush until it takes effect.
- Flush coinciding with completion: completion takes priority and flush has no further effect (the register is now empty).
- out_any = |out_word. It is registered alongside out_word.
- State view:
  - IDLE: cnt = 0.
  - FILL: cnt = 1..3 with in_ready = 1.
  - STALL: cnt = 3 and out_valid & !out_ready; in_ready = 0.
  - STALL exits to FILL on drain, or directly to IDLE if a bit is accepted in the drain cycle (completion).

## Timing
- Reset: when reset_n = 0 at a rising edge, all of the following take effect at that edge, regardless of in-flight data (partial sr contents are discarded):
  - out_valid = 0, out_word = 0, out_any = 0
  - fill = 0, sr = 0
- in_ready = 0 combinationally while reset_n = 0.
- Latency: the 4th bit accepted at edge N gives out_valid = 1 and a valid out_word in the cycle after edge N.
- Flush latency: flush at edge N gives out_valid after edge N.
- Throughput: one bit per cycle sustained with out_ready held high. A full word is emitted every 4 cycles with no bubbles, including a drain and a load at the same edge.
- out_word, out_valid and out_any are stable while out_valid & !out_ready.
- in_ready depends combinationally on out_ready, so there is no registered backpressure.

## Test plan
- Reset: hold reset_n = 0 for 2 edges with in_valid = 1 → out_valid = 0, out_word = 0, out_any = 0, fill = 0, in_ready = 0. After release, in_ready = 1.
- Basic word: accept bits 1,1,0,0 with out_ready = 1 → one cycle after the 4th edge: out_word = 4'b0011, out_any = 1, fill = 0. out_valid drops after the next edge.
- Zero word and back-to-back: stream 8 zero bits continuously, out_ready = 1 → two words of 4'b0000 with out_any = 0, out_valid high for 1 cycle every 4, in_ready never low.
- Backpressure: out_ready = 0, send 4'b1010 then 3 more bits → the 4th bit of the second word stalls with fill = 3 and in_ready = 0, and out_word stays 4'b1010. Raise out_ready → drain and load in the same edge, and out_word = the second word next cycle.
- Flush: accept bits 1,0 then assert flush for 1 cycle → out_word = 4'b0001, out_valid = 1, fill = 0. Flush with fill = 0 and no bit accepted → no output. Flush in the same cycle as a 3rd accepted bit 1 → out_word = 4'b0101 (prior bits 1,0).
- Mid-operation reset: fill = 2 and out_valid = 1, assert reset_n = 0 for 1 edge → all outputs 0. The next 4 accepted bits 1,0,0,0 produce out_word = 4'b0001.
